vga_cpu_readback: RTL and testbench

- CPU read-side responder for the 160x120, 3-bit-colour VGA framebuffer; complements the existing write-only CPU register path (X, Y, colour, draw).
- Lets the 6502 read back the current X/Y pointer, the framebuffer pixel at that pointer, and a status byte.
- Runs entirely in the 50 MHz CLK domain: samples the CPU bus through synchronizers and arbitrates one framebuffer read port against the display scan-out.

---
 rtl/vga_cpu_readback.sv | 196 +++++++++++++++++++
 tb/tb_vga_cpu_readback.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_cpu_readback.sv
// CPU read-back responder for the 160x120, 3-bit VGA framebuffer: lets the 6502
// read the X/Y pointer, the pixel under that pointer and a status byte.
module vga_cpu_readback #(
    parameter int H_PIX       = 160,
    parameter int V_PIX       = 120,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESB,
    input  logic       CPU_CLK,
    input  logic       CE,
    input  logic       RWB,
    input  logic [1:0] ADDR,
    input  logic [7:0] X_COORD,
    input  logic [7:0] Y_COORD,
    input  logic       DRAW_STROBE,
    input  logic       VBLANK,
    output logic       FB_RREQ,
    output logic [7:0] FB_RX,
    output logic [6:0] FB_RY,
    input  logic       FB_RGNT,
    input  logic [2:0] FB_RDATA,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE
);
    localparam logic [8:0] H_LIM = 9'(H_PIX);
    localparam logic [8:0] V_LIM = 9'(V_PIX);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] phi_sync_q, ce_sync_q, rwb_sync_q;
    logic                   phi_last_q;
    logic [7:0]             fb_rx_q, fb_rx_d;
    logic [6:0]             fb_ry_q, fb_ry_d;
    logic [7:0]             last_x_q, last_x_d;
    logic [7:0]             last_y_q, last_y_d;
    logic [2:0]             pixel_q, pixel_d;
    logic                   pix_valid_q, pix_valid_d;
    logic                   oor_q, oor_d;
    logic [7:0]             data_out_q, data_out_d;
    logic                   data_oe_q, data_oe_d;

    logic       phi_s, ce_s, rwb_s;
    logic       phi_rise, phi_fall;
    logic       coord_change, coord_oor, trigger;
    logic       busy, fb_rreq;
    logic [7:0] reg_rdata;

    assign phi_s    = phi_sync_q[SYNC_STAGES-1];
    assign ce_s     = ce_sync_q[SYNC_STAGES-1];
    assign rwb_s    = rwb_sync_q[SYNC_STAGES-1];
    assign phi_rise = phi_s & ~phi_last_q;
    assign phi_fall = ~phi_s & phi_last_q;

    // Range check uses all 8 bits even though only Y[6:0] reaches FB_RY.
    assign coord_change = (X_COORD != last_x_q) || (Y_COORD != last_y_q);
    assign coord_oor    = ({1'b0, X_COORD} >= H_LIM) || ({1'b0, Y_COORD} >= V_LIM);
    assign trigger      = coord_change || DRAW_STROBE || !pix_valid_q;

    // State register and all other sequential state.
    always_ff @(posedge CLK) begin
        if (!RESB) begin
            state_q     <= S_IDLE;
            phi_sync_q  <= '0;
            ce_sync_q   <= '0;
            rwb_sync_q  <= '0;
            phi_last_q  <= 1'b0;
            fb_rx_q     <= '0;
            fb_ry_q     <= '0;
            last_x_q    <= '0;
            last_y_q    <= '0;
            pixel_q     <= '0;
            pix_valid_q <= 1'b0;
            oor_q       <= 1'b0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            phi_sync_q  <= {phi_sync_q[SYNC_STAGES-2:0], CPU_CLK};
            ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], CE};
            rwb_sync_q  <= {rwb_sync_q[SYNC_STAGES-2:0], RWB};
            phi_last_q  <= phi_s;
            fb_rx_q     <= fb_rx_d;
            fb_ry_q     <= fb_ry_d;
            last_x_q    <= last_x_d;
            last_y_q    <= last_y_d;
            pixel_q     <= pixel_d;
            pix_valid_q <= pix_valid_d;
            oor_q       <= oor_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
        end
    end

    // Next-state logic for the fetch FSM.
    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_d     = state_q;
        fb_rx_d     = fb_rx_q;
        fb_ry_d     = fb_ry_q;
        last_x_d    = last_x_q;
        last_y_d    = last_y_q;
        pixel_d     = pixel_q;
        pix_valid_d = pix_valid_q;
        oor_d       = oor_q;
        unique case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    last_x_d = X_COORD;
                    last_y_d = Y_COORD;
                    if (coord_oor) begin
                        oor_d       = 1'b1;
                        pixel_d     = '0;
                        pix_valid_d = 1'b1;
                    end else begin
                        oor_d       = 1'b0;
                        pix_valid_d = 1'b0;
                        fb_rx_d     = X_COORD;
                        fb_ry_d     = Y_COORD[6:0];
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // A pointer move retargets the pending request; an out-of-range
                // move drops back to IDLE, where pix_valid=0 resolves it.
                if (coord_change) begin
                    last_x_d = X_COORD;
                    last_y_d = Y_COORD;
                    if (coord_oor) begin
                        state_d = S_IDLE;
                    end else begin
                        fb_rx_d = X_COORD;
                        fb_ry_d = Y_COORD[6:0];
                    end
                end else if (FB_RGNT) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (coord_change || DRAW_STROBE) begin
                    last_x_d = X_COORD;
                    last_y_d = Y_COORD;
                    if (coord_oor) begin
                        state_d = S_IDLE;
                    end else begin
                        fb_rx_d = X_COORD;
                        fb_ry_d = Y_COORD[6:0];
                        state_d = S_REQ;
                    end
                end else begin
                    pixel_d     = FB_RDATA;
                    pix_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy    = (state_q != S_IDLE);
        fb_rreq = (state_q == S_REQ);
    end

    always_comb begin
        unique case (ADDR)
            2'd0:    reg_rdata = X_COORD;
            2'd1:    reg_rdata = Y_COORD;
            2'd2:    reg_rdata = {5'b0, pixel_q};
            default: reg_rdata = {busy, 4'b0, oor_q, pix_valid_q, VBLANK};
        endcase
    end

    // Bus side: snapshot at PHI2 rise so DATA_OUT is stable for the whole cycle.
    always_comb begin
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;
        if (phi_rise && !ce_s && rwb_s) begin
            data_out_d = reg_rdata;
            data_oe_d  = 1'b1;
        end else if (phi_fall || ce_s) begin
            data_oe_d  = 1'b0;
        end
    end

    assign FB_RREQ  = fb_rreq;
    assign FB_RX    = fb_rx_q;
    assign FB_RY    = fb_ry_q;
    assign DATA_OUT = data_out_q;
    assign DATA_OE  = data_oe_q;

endmodule

// File: tb/tb_vga_cpu_readback.sv
// Directed bench for vga_cpu_readback: a framebuffer model answers grants, and
// expected CPU read data goes through a scoreboard queue.
module tb_vga_cpu_readback;

    logic       CLK = 1'b0;
    logic       RESB;
    logic       CPU_CLK;
    logic       CE;
    logic       RWB;
    logic [1:0] ADDR;
    logic [7:0] X_COORD;
    logic [7:0] Y_COORD;
    logic       DRAW_STROBE;
    logic       VBLANK;
    logic       FB_RREQ;
    logic [7:0] FB_RX;
    logic [6:0] FB_RY;
    logic       FB_RGNT;
    logic [2:0] FB_RDATA;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;

    logic [2:0] fb_mem [0:255][0:127];
    logic [7:0] sb [$];
    logic [7:0] last_exp;
    int         vectors     = 0;
    int         miscompares = 0;

    vga_cpu_readback #(.H_PIX(160), .V_PIX(120), .SYNC_STAGES(2)) dut (
        .CLK         (CLK),
        .RESB        (RESB),
        .CPU_CLK     (CPU_CLK),
        .CE          (CE),
        .RWB         (RWB),
        .ADDR        (ADDR),
        .X_COORD     (X_COORD),
        .Y_COORD     (Y_COORD),
        .DRAW_STROBE (DRAW_STROBE),
        .VBLANK      (VBLANK),
        .FB_RREQ     (FB_RREQ),
        .FB_RX       (FB_RX),
        .FB_RY       (FB_RY),
        .FB_RGNT     (FB_RGNT),
        .FB_RDATA    (FB_RDATA),
        .DATA_OUT    (DATA_OUT),
        .DATA_OE     (DATA_OE)
    );

    always #5 CLK = ~CLK;

    // Framebuffer read port: data is valid only in the cycle after a grant.
    always @(posedge CLK) begin
        if (FB_RREQ && FB_RGNT) FB_RDATA <= fb_mem[FB_RX][FB_RY];
        else                    FB_RDATA <= 3'bxxx;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] status(input logic busy, input logic oor,
                                          input logic pv, input logic vb);
        return {busy, 4'b0000, oor, pv, vb};
    endfunction

    task automatic bus_begin(input logic [1:0] addr, input logic rwb, input logic ce);
        @(negedge CLK);
        ADDR = addr;
        RWB  = rwb;
        CE   = ce;
        repeat (3) @(negedge CLK);
        #2;
        CPU_CLK = 1'b1;
    endtask

    task automatic bus_end();
        @(negedge CLK);
        #2;
        CPU_CLK = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (!DATA_OE) break;
        end
        check("oe_fall", {7'b0, DATA_OE}, 8'h00);
        CE  = 1'b1;
        RWB = 1'b1;
    endtask

    task automatic rd_start(input logic [1:0] addr, input logic [7:0] exp);
        sb.push_back(exp);
        bus_begin(addr, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (DATA_OE) break;
        end
        check("oe_rise", {7'b0, DATA_OE}, 8'h01);
        last_exp = sb.pop_front();
        check("rd_data", DATA_OUT, last_exp);
    endtask

    task automatic rd_finish();
        repeat (4) begin
            @(negedge CLK);
            check("oe_hold", {7'b0, DATA_OE}, 8'h01);
            check("rd_hold", DATA_OUT, last_exp);
        end
        bus_end();
    endtask

    task automatic cpu_read(input logic [1:0] addr, input logic [7:0] exp);
        rd_start(addr, exp);
        rd_finish();
    endtask

    task automatic no_drive(input logic [1:0] addr, input logic rwb, input logic ce);
        bus_begin(addr, rwb, ce);
        repeat (8) begin
            @(negedge CLK);
            check("oe_quiet", {7'b0, DATA_OE}, 8'h00);
        end
        bus_end();
    endtask

    initial begin
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 128; y++)
                fb_mem[x][y] = 3'(x + y);
        fb_mem[10][10]   = 3'b001;
        fb_mem[159][119] = 3'b101;
        fb_mem[30][20]   = 3'b100;
        fb_mem[40][20]   = 3'b011;
        fb_mem[50][50]   = 3'b010;
        fb_mem[60][60]   = 3'b111;

        RESB = 1'b0; CPU_CLK = 1'b0; CE = 1'b1; RWB = 1'b1; ADDR = 2'd0;
        X_COORD = 8'd10; Y_COORD = 8'd10; DRAW_STROBE = 1'b0; VBLANK = 1'b0;
        FB_RGNT = 1'b1;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_data_out", DATA_OUT, 8'h00);
        check("rst_data_oe", {7'b0, DATA_OE}, 8'h00);
        check("rst_rreq", {7'b0, FB_RREQ}, 8'h00);
        check("rst_rx", FB_RX, 8'h00);
        check("rst_ry", {1'b0, FB_RY}, 8'h00);
        RESB = 1'b1;

        // First fetch at (10,10), grant tied high
        @(negedge CLK);
        check("f1_rreq", {7'b0, FB_RREQ}, 8'h01);
        check("f1_rx", FB_RX, 8'd10);
        check("f1_ry", {1'b0, FB_RY}, 8'd10);
        @(negedge CLK);
        check("f1_data_rreq", {7'b0, FB_RREQ}, 8'h00);
        @(negedge CLK);
        cpu_read(2'd2, 8'h01);
        cpu_read(2'd3, status(1'b0, 1'b0, 1'b1, 1'b0));
        VBLANK = 1'b1;
        cpu_read(2'd3, status(1'b0, 1'b0, 1'b1, 1'b1));
        VBLANK = 1'b0;
        cpu_read(2'd0, 8'd10);
        cpu_read(2'd1, 8'd10);

        // Out of range on X
        @(negedge CLK);
        X_COORD = 8'd200; Y_COORD = 8'd5;
        repeat (4) begin
            @(negedge CLK);
            check("oor_x_rreq", {7'b0, FB_RREQ}, 8'h00);
        end
        cpu_read(2'd3, 8'h06);
        cpu_read(2'd2, 8'h00);
        cpu_read(2'd0, 8'd200);

        // Y=130 would alias to 2 in 7 bits; must still be out of range
        @(negedge CLK);
        X_COORD = 8'd10; Y_COORD = 8'd130;
        repeat (3) begin
            @(negedge CLK);
            check("oor_y_rreq", {7'b0, FB_RREQ}, 8'h00);
        end
        cpu_read(2'd3, 8'h06);

        // Last in-range pixel, then first out-of-range column
        @(negedge CLK);
        X_COORD = 8'd159; Y_COORD = 8'd119;
        @(negedge CLK);
        check("edge_rreq", {7'b0, FB_RREQ}, 8'h01);
        check("edge_rx", FB_RX, 8'd159);
        check("edge_ry", {1'b0, FB_RY}, 8'd119);
        repeat (3) @(negedge CLK);
        cpu_read(2'd2, 8'h05);
        cpu_read(2'd3, 8'h02);
        @(negedge CLK);
        X_COORD = 8'd160; Y_COORD = 8'd0;
        repeat (2) begin
            @(negedge CLK);
            check("oor_160_rreq", {7'b0, FB_RREQ}, 8'h00);
        end
        cpu_read(2'd3, 8'h06);

        // Grant withheld while X moves 30 -> 40
        @(negedge CLK);
        FB_RGNT = 1'b0;
        X_COORD = 8'd30; Y_COORD = 8'd20;
        repeat (2) @(negedge CLK);
        check("wait_rreq", {7'b0, FB_RREQ}, 8'h01);
        check("wait_rx30", FB_RX, 8'd30);
        cpu_read(2'd3, status(1'b1, 1'b0, 1'b0, 1'b0));
        X_COORD = 8'd40;
        repeat (5) @(negedge CLK);
        check("wait_rreq_held", {7'b0, FB_RREQ}, 8'h01);
        check("wait_rx40", FB_RX, 8'd40);
        FB_RGNT = 1'b1;
        @(negedge CLK);
        check("wait_granted", {7'b0, FB_RREQ}, 8'h00);
        repeat (2) @(negedge CLK);
        cpu_read(2'd2, 8'h03);
        cpu_read(2'd3, 8'h02);

        // DRAW_STROBE while in DATA discards the in-flight pixel
        @(negedge CLK);
        X_COORD = 8'd50; Y_COORD = 8'd50;
        @(negedge CLK);
        check("draw_req1", {7'b0, FB_RREQ}, 8'h01);
        @(negedge CLK);
        fb_mem[50][50] = 3'b110;
        DRAW_STROBE = 1'b1;
        @(negedge CLK);
        DRAW_STROBE = 1'b0;
        check("draw_req2", {7'b0, FB_RREQ}, 8'h01);
        repeat (3) @(negedge CLK);
        cpu_read(2'd2, 8'h06);

        // Write cycle and deselected read never drive the bus
        no_drive(2'd0, 1'b0, 1'b0);
        no_drive(2'd0, 1'b1, 1'b1);

        // CE rising mid-cycle releases the bus while PHI2 is still high
        rd_start(2'd0, 8'd50);
        CE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (!DATA_OE) break;
        end
        check("ce_abort_oe", {7'b0, DATA_OE}, 8'h00);
        bus_end();

        // Reset while in REQ with a CPU read in progress
        @(negedge CLK);
        FB_RGNT = 1'b0;
        X_COORD = 8'd60; Y_COORD = 8'd60;
        repeat (2) @(negedge CLK);
        check("rstreq_rreq", {7'b0, FB_RREQ}, 8'h01);
        rd_start(2'd0, 8'd60);
        RESB = 1'b0;
        @(negedge CLK);
        check("rstreq_rreq_low", {7'b0, FB_RREQ}, 8'h00);
        check("rstreq_oe_low", {7'b0, DATA_OE}, 8'h00);
        check("rstreq_data_out", DATA_OUT, 8'h00);
        CPU_CLK = 1'b0;
        CE      = 1'b1;
        FB_RGNT = 1'b1;
        repeat (3) @(negedge CLK);
        check("rstreq_sb_empty", 8'(sb.size()), 8'h00);
        RESB = 1'b1;
        @(negedge CLK);
        check("refetch_rreq", {7'b0, FB_RREQ}, 8'h01);
        check("refetch_rx", FB_RX, 8'd60);
        check("refetch_ry", {1'b0, FB_RY}, 8'd60);
        check("refetch_oe", {7'b0, DATA_OE}, 8'h00);
        repeat (3) @(negedge CLK);
        cpu_read(2'd2, 8'h07);
        cpu_read(2'd3, 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
